// File: rtl/sdf_butterfly_stage_pkg.sv
// Shared types and arithmetic for the radix-2 SDF butterfly stage.
// cplx_t is width-parametric through a macro because a package cannot see module parameters.
`define SDF_CPLX_T(W) struct packed { logic signed [(W)-1:0] re; logic signed [(W)-1:0] im; }

package sdf_pkg;

  localparam int unsigned MAX_W = 32;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return (depth > 1) ? $clog2(2 * depth) : 1;
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // v is a sign-extended w+1-bit value; result fits in w bits, upper bits are sign copies.
  function automatic logic signed [MAX_W-1:0] scale_sat(
    input  logic signed [MAX_W:0] v,
    input  int unsigned           w,
    input  logic                  mode,
    input  logic                  rh,
    output logic                  ovfbit
  );
    logic signed [MAX_W:0] hi;
    logic signed [MAX_W:0] lo;
    logic signed [MAX_W:0] r;
    hi     = ($signed({{MAX_W{1'b0}}, 1'b1}) <<< (w - 1)) - $signed({{MAX_W{1'b0}}, 1'b1});
    lo     = -hi - $signed({{MAX_W{1'b0}}, 1'b1});
    ovfbit = 1'b0;
    if (mode) begin
      r = (v + $signed({{MAX_W{1'b0}}, rh})) >>> 1;
    end else if (v > hi) begin
      r      = hi;
      ovfbit = 1'b1;
    end else if (v < lo) begin
      r      = lo;
      ovfbit = 1'b1;
    end else begin
      r = v;
    end
    return r[MAX_W-1:0];
  endfunction

endpackage

// File: rtl/sdf_butterfly_stage_delay_buffer.sv
// DEPTH-sample circular delay line; read-before-write at the shared pointer.
module sdf_delay_buffer
  import sdf_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64
) (
  input  logic                              clock,
  input  logic                              wr_en,
  input  logic [ptr_width(DEPTH)-1:0]       ptr,
  input  logic [2*WIDTH-1:0]                wdata,
  output logic [2*WIDTH-1:0]                rdata
);

  if (DEPTH > 1) begin : g_ram
    logic [2*WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
      if (wr_en) mem[ptr] <= wdata;
    end

    assign rdata = mem[ptr];
  end else begin : g_reg
    logic [2*WIDTH-1:0] r;

    always_ff @(posedge clock) begin
      if (wr_en) r <= wdata;
    end

    assign rdata = r;
  end

endmodule

// File: rtl/sdf_butterfly_stage.sv
// Radix-2 single-path delay-feedback butterfly stage with stall, per-frame scale/saturate
// mode and sticky overflow.
module sdf_butterfly_stage
  import sdf_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64,
  parameter int RH    = 0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    di_en,
  input  logic signed [WIDTH-1:0] di_re,
  input  logic signed [WIDTH-1:0] di_im,
  input  logic                    scale_en,
  input  logic                    ovf_clr,
  output logic                    do_en,
  output logic signed [WIDTH-1:0] do_re,
  output logic signed [WIDTH-1:0] do_im,
  output logic                    ovf
);

  localparam int unsigned CNT_W = cnt_width(DEPTH);
  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam logic        RH_B  = (RH != 0);

  typedef `SDF_CPLX_T(WIDTH) cplx_t;
  typedef enum logic {MODE_SAT = 1'b0, MODE_SCALE = 1'b1} mode_t;

  logic [CNT_W-1:0] cnt;
  logic [PTR_W-1:0] ptr;
  logic             phase;
  logic             primed;
  mode_t            mode_q;
  mode_t            mode_eff;
  cplx_t            head;
  cplx_t            wr;
  cplx_t            res;
  logic             sat_any;
  logic             emit;

  function automatic logic signed [MAX_W:0] sext(input logic signed [WIDTH-1:0] x);
    return {{(MAX_W + 1 - WIDTH){x[WIDTH-1]}}, x};
  endfunction

  function automatic logic signed [WIDTH-1:0] fsat(
    input  logic signed [MAX_W:0] v,
    input  logic                  mode,
    output logic                  ob
  );
    logic signed [MAX_W-1:0] full;
    full = scale_sat(v, WIDTH, mode, RH_B, ob);
    return full[WIDTH-1:0];
  endfunction

  assign phase = cnt[CNT_W-1];

  if (DEPTH > 1) begin : g_ptr
    assign ptr = cnt[PTR_W-1:0];
  end else begin : g_ptr1
    assign ptr = '0;
  end

  sdf_delay_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_buf (
    .clock (clock),
    .wr_en (di_en),
    .ptr   (ptr),
    .wdata (wr),
    .rdata (head)
  );

  // The frame's mode is taken straight from scale_en on its first sample.
  assign mode_eff = (cnt == '0) ? mode_t'(scale_en) : mode_q;
  assign emit     = di_en & (phase | primed);

  always_comb begin
    logic signed [MAX_W:0] s_re, s_im, d_re, d_im;
    logic o0, o1, o2, o3;
    cplx_t fs, fd;
    s_re  = sext(head.re) + sext(di_re);
    s_im  = sext(head.im) + sext(di_im);
    d_re  = sext(head.re) - sext(di_re);
    d_im  = sext(head.im) - sext(di_im);
    fs.re = fsat(s_re, mode_eff == MODE_SCALE, o0);
    fs.im = fsat(s_im, mode_eff == MODE_SCALE, o1);
    fd.re = fsat(d_re, mode_eff == MODE_SCALE, o2);
    fd.im = fsat(d_im, mode_eff == MODE_SCALE, o3);
    sat_any = di_en & phase & (o0 | o1 | o2 | o3);
    if (phase) begin
      wr  = fd;
      res = fs;
    end else begin
      wr.re = di_re;
      wr.im = di_im;
      res   = head;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      primed <= 1'b0;
      mode_q <= MODE_SCALE;
      do_en  <= 1'b0;
      do_re  <= '0;
      do_im  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (di_en) begin
        cnt <= cnt + CNT_W'(1);
        if (cnt == '0) mode_q <= mode_t'(scale_en);
        if (cnt == CNT_W'(DEPTH)) primed <= 1'b1;
      end
      do_en <= emit;
      if (emit) begin
        do_re <= res.re;
        do_im <= res.im;
      end
      if (sat_any)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sdf_butterfly_stage.sv
// Directed self-checking bench for sdf_butterfly_stage at WIDTH=16, DEPTH=4 (RH=0 and RH=1).
module tb_sdf_butterfly_stage;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic di_en = 1'b0;
  logic signed [15:0] di_re = '0;
  logic signed [15:0] di_im = '0;
  logic scale_en = 1'b1;
  logic ovf_clr = 1'b0;

  logic do_en0, do_en1, ovf0, ovf1;
  logic signed [15:0] do_re0, do_im0, do_re1, do_im1;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  sdf_butterfly_stage #(.WIDTH(16), .DEPTH(4), .RH(0)) u0 (
    .clock(clock), .reset_n(reset_n), .di_en(di_en), .di_re(di_re), .di_im(di_im),
    .scale_en(scale_en), .ovf_clr(ovf_clr),
    .do_en(do_en0), .do_re(do_re0), .do_im(do_im0), .ovf(ovf0)
  );

  sdf_butterfly_stage #(.WIDTH(16), .DEPTH(4), .RH(1)) u1 (
    .clock(clock), .reset_n(reset_n), .di_en(di_en), .di_re(di_re), .di_im(di_im),
    .scale_en(scale_en), .ovf_clr(ovf_clr),
    .do_en(do_en1), .do_re(do_re1), .do_im(do_im1), .ovf(ovf1)
  );

  task automatic step(input logic en, input int re, input int im);
    di_en = en;
    di_re = 16'(re);
    di_im = 16'(im);
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    di_en   = 1'b0;
    ovf_clr = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (do_en0 !== 1'b0 || do_re0 !== 16'sd0 || ovf0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: do_en=%b do_re=%0d ovf=%b, required 0 0 0", do_en0, do_re0, ovf0);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      di_en = i[0];
      di_re = 16'(1000 + i);
      di_im = 16'(-7 * i);
      @(posedge clock);
      #1;
      checks++;
      if (do_en0 !== 1'b0 || do_re0 !== 16'sd0 || do_im0 !== 16'sd0 || ovf0 !== 1'b0 ||
          do_en1 !== 1'b0 || do_re1 !== 16'sd0 || do_im1 !== 16'sd0 || ovf1 !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: do_en=%b/%b do_re=%0d/%0d do_im=%0d/%0d ovf=%b/%b, required all 0",
                 i, do_en0, do_en1, do_re0, do_re1, do_im0, do_im1, ovf0, ovf1);
      end
    end
    di_en = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    int re, im, ere, eim;
    logic een;
    apply_reset();
    scale_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      re = (i < 4) ? 100 : (i < 8) ? 20 : 0;
      im = (i < 4) ? -50 : (i < 8) ? 10 : 0;
      step(1'b1, re, im);
      een = (i >= 4);
      ere = (i < 4) ? 0 : (i < 8) ? 60 : 40;
      eim = (i < 4) ? 0 : (i < 8) ? -20 : -30;
      checks++;
      if (do_en0 !== een || int'(do_re0) != ere || int'(do_im0) != eim) begin
        errors++;
        $display("FAIL basic[%0d]: do_en=%b re=%0d im=%0d, required %b %0d %0d",
                 i, do_en0, do_re0, do_im0, een, ere, eim);
      end
    end
    di_en = 1'b0;
  endtask

  task automatic test_saturate();
    apply_reset();
    scale_en = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 30000, 0);
    checks++;
    if (do_en0 !== 1'b0 || ovf0 !== 1'b0) begin
      errors++;
      $display("FAIL sat_fill: do_en=%b ovf=%b, required 0 0", do_en0, ovf0);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 30000, 0);
      checks++;
      if (do_en0 !== 1'b1 || int'(do_re0) != 32767 || int'(do_im0) != 0 || ovf0 !== 1'b1) begin
        errors++;
        $display("FAIL sat_pos[%0d]: do_en=%b re=%0d im=%0d ovf=%b, required 1 32767 0 1",
                 i, do_en0, do_re0, do_im0, ovf0);
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, -30000, 0);
      checks++;
      if (do_en0 !== 1'b1 || int'(do_re0) != 0) begin
        errors++;
        $display("FAIL sat_diff[%0d]: do_en=%b re=%0d, required 1 0", i, do_en0, do_re0);
      end
    end
    for (int i = 0; i < 4; i++) begin
      ovf_clr = (i == 0);
      step(1'b1, -30000, 0);
      checks++;
      if (int'(do_re0) != -32768 || ovf0 !== 1'b1) begin
        errors++;
        $display("FAIL sat_neg[%0d]: re=%0d ovf=%b, required -32768 1", i, do_re0, ovf0);
      end
    end
    ovf_clr = 1'b1;
    step(1'b1, 0, 0);
    ovf_clr = 1'b0;
    checks++;
    if (ovf0 !== 1'b0 || int'(do_re0) != 0 || do_en0 !== 1'b1) begin
      errors++;
      $display("FAIL ovf_clear: ovf=%b re=%0d do_en=%b, required 0 0 1", ovf0, do_re0, do_en0);
    end
    step(1'b1, 0, 0);
    checks++;
    if (ovf0 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_stays_clear: ovf=%b, required 0", ovf0);
    end
    di_en = 1'b0;
  endtask

  task automatic test_rounding();
    apply_reset();
    scale_en = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 1, -1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2, -2);
      checks++;
      if (int'(do_re0) != 1 || int'(do_im0) != -2 || int'(do_re1) != 2 || int'(do_im1) != -1) begin
        errors++;
        $display("FAIL round_sum[%0d]: rh0=%0d,%0d rh1=%0d,%0d, required 1,-2 2,-1",
                 i, do_re0, do_im0, do_re1, do_im1);
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 0, 0);
      checks++;
      if (int'(do_re0) != -1 || int'(do_im0) != 0 || int'(do_re1) != 0 || int'(do_im1) != 1) begin
        errors++;
        $display("FAIL round_diff[%0d]: rh0=%0d,%0d rh1=%0d,%0d, required -1,0 0,1",
                 i, do_re0, do_im0, do_re1, do_im1);
      end
    end
    di_en = 1'b0;
  endtask

  task automatic test_stalls();
    int exp_re[8] = '{60, 60, 60, 60, 40, 40, 40, 40};
    int exp_im[8] = '{-20, -20, -20, -20, -30, -30, -30, -30};
    int idx = 0;
    int n_out = 0;
    int last_re = 0;
    int last_im = 0;
    logic en;
    apply_reset();
    scale_en = 1'b1;
    void'($urandom(32'd2024));
    for (int c = 0; c < 200 && idx < 12; c++) begin
      en = 1'($urandom_range(0, 1));
      if (en) begin
        step(1'b1, (idx < 4) ? 100 : (idx < 8) ? 20 : 0, (idx < 4) ? -50 : (idx < 8) ? 10 : 0);
        idx++;
      end else begin
        step(1'b0, 12345, -999);
      end
      checks++;
      if (do_en0 === 1'b1) begin
        if (!en || n_out >= 8 || int'(do_re0) != exp_re[n_out] || int'(do_im0) != exp_im[n_out]) begin
          errors++;
          $display("FAIL stall_out[%0d]: en=%b re=%0d im=%0d, required en=1 re=%0d im=%0d",
                   n_out, en, do_re0, do_im0, (n_out < 8) ? exp_re[n_out] : 0,
                   (n_out < 8) ? exp_im[n_out] : 0);
        end
        last_re = int'(do_re0);
        last_im = int'(do_im0);
        n_out++;
      end else if (int'(do_re0) != last_re || int'(do_im0) != last_im) begin
        errors++;
        $display("FAIL stall_hold: re=%0d im=%0d, required %0d %0d", do_re0, do_im0, last_re, last_im);
      end
    end
    checks++;
    if (idx != 12 || n_out != 8) begin
      errors++;
      $display("FAIL stall_count: inputs=%0d outputs=%0d, required 12 8", idx, n_out);
    end
    di_en = 1'b0;
  endtask

  task automatic test_mode_reset();
    apply_reset();
    scale_en = 1'b1;
    step(1'b1, 100, 0);
    scale_en = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 100, 0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 20, 0);
      checks++;
      if (int'(do_re0) != 60) begin
        errors++;
        $display("FAIL mode_hold_scaled[%0d]: re=%0d, required 60", i, do_re0);
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 0, 0);
      checks++;
      if (int'(do_re0) != 40) begin
        errors++;
        $display("FAIL mode_prev_diff[%0d]: re=%0d, required 40", i, do_re0);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 1) scale_en = 1'b1;
      step(1'b1, 20, 0);
      checks++;
      if (int'(do_re0) != 20 || ovf0 !== 1'b0) begin
        errors++;
        $display("FAIL mode_unscaled[%0d]: re=%0d ovf=%b, required 20 0", i, do_re0, ovf0);
      end
    end
    apply_reset();
    scale_en = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b1, 100, 0);
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8, 0);
      checks++;
      if (do_en0 !== 1'b0) begin
        errors++;
        $display("FAIL reset_midframe_quiet[%0d]: do_en=%b, required 0", i, do_en0);
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2, 0);
      checks++;
      if (do_en0 !== 1'b1 || int'(do_re0) != 5) begin
        errors++;
        $display("FAIL reset_midframe_out[%0d]: do_en=%b re=%0d, required 1 5", i, do_en0, do_re0);
      end
    end
    di_en = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_saturate();
    test_rounding();
    test_stalls();
    test_mode_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
